// File: rtl/freq_gen_pkg.sv
// freq_pkg: shared state encoding and default widths for the freq_gen NCO square-wave generator.
package freq_pkg;
    localparam int ACC_W_DEF = 32;
    localparam int CNT_W_DEF = 40;
    localparam logic [ACC_W_DEF-1:0] HALF_WORD = {2'b01, {(ACC_W_DEF-2){1'b0}}};
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
endpackage

// File: rtl/freq_gen_if.sv
// freq_gen_if: control and status bundle of freq_gen; FREQ_GEN_GATE_EN adds the period gate.
interface freq_gen_if import freq_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic [ACC_W-1:0] freq_word;
    logic             load;
    logic [CNT_W-1:0] burst_len;
    logic             start;
    logic             stop;
    logic             signal_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] edge_count;
`ifdef FREQ_GEN_GATE_EN
    logic             period;
`endif
    modport master (
        output freq_word, load, burst_len, start, stop,
        input  signal_out, busy, done, edge_count
`ifdef FREQ_GEN_GATE_EN
        , input period
`endif
    );
    modport slave (
        input  freq_word, load, burst_len, start, stop,
        output signal_out, busy, done, edge_count
`ifdef FREQ_GEN_GATE_EN
        , output period
`endif
    );
endinterface

// File: rtl/freq_gen_nco.sv
// freq_gen_nco: phase accumulator with shadow/active frequency word swapped only on accumulator wrap.
module freq_gen_nco import freq_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [ACC_W-1:0] freq_word,
    output logic             msb,
    output logic             rise
);
    logic [ACC_W-1:0] acc, shadow_word, active_word, sum;
    logic             carry;
    assign {carry, sum} = {1'b0, acc} + {1'b0, active_word};
    assign msb  = acc[ACC_W-1];
    assign rise = en && !acc[ACC_W-1] && sum[ACC_W-1];
    // swapping the word only on wrap keeps every period whole, so no runt pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            shadow_word <= '0;
            active_word <= '0;
        end else begin
            shadow_word <= load ? freq_word : shadow_word;
            acc         <= clr ? '0 : en ? sum : acc;
            active_word <= (clr || (en && carry)) ? shadow_word : active_word;
        end
    end
endmodule

// File: rtl/freq_gen.sv
// freq_gen: NCO square-wave generator with continuous/burst modes; FREQ_GEN_GATE_EN adds a period gate output.
module freq_gen import freq_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic       clk,
    input logic       reset,
    freq_gen_if.slave bus
);
    state_t           state, state_nx;
    logic             msb, rise, en, clr, burst_hit, done;
    logic [CNT_W-1:0] edge_count, burst_target, edge_inc;

    freq_gen_nco #(.ACC_W(ACC_W)) u_nco (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .load(bus.load), .freq_word(bus.freq_word), .msb(msb), .rise(rise)
    );

    assign edge_inc  = &edge_count ? edge_count : edge_count + 1'b1;
    assign burst_hit = rise && burst_target != '0 && edge_inc == burst_target;

    always_ff @(posedge clk) state <= reset ? IDLE : state_nx;

    always_comb begin
        state_nx = bus.start                          ? RUN    :
                   state == RUN && (bus.stop || burst_hit) ? FINISH :
                   state == FINISH && !msb            ? IDLE   : state;
    end

    // FINISH only advances the accumulator while high, so it can never produce a rising edge
    always_comb begin
        en  = !bus.start && (state == RUN || (state == FINISH && msb));
        clr = bus.start || state == IDLE || (state == FINISH && !msb);
    end

    always_ff @(posedge clk) begin
        if (reset || bus.start) begin
            edge_count   <= '0;
            burst_target <= reset ? '0 : bus.burst_len;
            done         <= 1'b0;
        end else begin
            edge_count   <= rise ? edge_inc : edge_count;
            done         <= state == FINISH && !msb;
        end
    end

    assign bus.signal_out = msb;
    assign bus.busy       = state != IDLE;
    assign bus.done       = done;
    assign bus.edge_count = edge_count;

`ifdef FREQ_GEN_GATE_EN
    logic period;
    // cleared during the first FINISH cycle so the gate still covers the burst's last edge
    always_ff @(posedge clk) period <= (reset || bus.start || state == FINISH) ? 1'b0 : rise ? 1'b1 : period;
    assign bus.period = period;
`endif
endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: scoreboard bench for freq_gen; covers the period gate when FREQ_GEN_GATE_EN is defined.
module tb_freq_gen;
    import freq_pkg::*;
    localparam int AW = 32;
    localparam int CW = 40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    freq_gen_if #(.ACC_W(AW), .CNT_W(CW)) bus ();
    freq_gen #(.ACC_W(AW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic          sig;
        logic          busy;
        logic          done;
        logic [CW-1:0] ec;
        logic          per;
    } exp_t;
    exp_t q[$];

    int total = 0, bad = 0;
    int ncyc = 0, n_done = 0, last_rise = -1, per_len = 0, hi_run = 0, min_hi = 1000, gated = 0;
    logic prev_sig = 1'b0;

    logic [AW-1:0] m_acc, m_sh, m_act;
    logic [CW-1:0] m_ec, m_bt;
    int            m_st;
    logic          m_done, m_per;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference: one clock of the generator written from the behavioural description
    task automatic model(input logic r, input logic ld, input logic st, input logic sp);
        logic [AW:0] s;
        logic        rz;
        if (r) begin
            m_acc = '0; m_sh = '0; m_act = '0; m_ec = '0; m_bt = '0;
            m_st = 0; m_done = 1'b0; m_per = 1'b0;
        end else begin
            s = {1'b0, m_acc} + {1'b0, m_act};
            m_done = 1'b0;
            if (st) begin
                m_st = 1; m_acc = '0; m_ec = '0; m_bt = bus.burst_len; m_act = m_sh; m_per = 1'b0;
            end else if (m_st == 1) begin
                rz = !m_acc[AW-1] && s[AW-1];
                if (s[AW]) m_act = m_sh;
                m_acc = s[AW-1:0];
                if (rz) begin
                    if (m_ec != '1) m_ec = m_ec + 1'b1;
                    m_per = 1'b1;
                end
                if (sp || (rz && m_bt != '0 && m_ec == m_bt)) m_st = 2;
            end else if (m_st == 2) begin
                m_per = 1'b0;
                if (!m_acc[AW-1]) begin
                    m_st = 0; m_acc = '0; m_done = 1'b1;
                end else begin
                    if (s[AW]) m_act = m_sh;
                    m_acc = s[AW-1:0];
                end
            end
            if (ld) m_sh = bus.freq_word;
        end
        q.push_back('{m_acc[AW-1], m_st != 0, m_done, m_ec, m_per});
    endtask

    task automatic cyc(input logic r, input logic ld, input logic st, input logic sp);
        exp_t e;
        reset = r; bus.load = ld; bus.start = st; bus.stop = sp;
        model(r, ld, st, sp);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("signal_out", bus.signal_out, e.sig);
        chk("busy", bus.busy, e.busy);
        chk("done", bus.done, e.done);
        chk("edge_count", bus.edge_count, e.ec);
`ifdef FREQ_GEN_GATE_EN
        chk("period", bus.period, e.per);
`endif
        ncyc++;
        if (bus.done) n_done++;
        if (bus.signal_out && !prev_sig) begin
            if (last_rise >= 0) per_len = ncyc - last_rise;
            last_rise = ncyc;
`ifdef FREQ_GEN_GATE_EN
            if (bus.period) gated++;
`endif
        end
        if (bus.signal_out) hi_run++;
        else begin
            if (prev_sig && hi_run < min_hi) min_hi = hi_run;
            hi_run = 0;
        end
        prev_sig = bus.signal_out;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.freq_word = '0; bus.burst_len = '0;
        bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; reset = 1'b1;
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        idle(2);

        // continuous at a quarter of the clock
        bus.freq_word = HALF_WORD;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        idle(20);
        chk("cont_period", per_len, 4);
        chk("cont_edges", bus.edge_count, 5);

        // stop while high: the high phase completes before done
        for (int i = 0; i < 8 && !bus.signal_out; i++) idle(1);
        chk("wait_high", bus.signal_out, 1);
        n_done = 0;
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 10 && bus.busy; i++) idle(1);
        chk("stop_high_done", n_done, 1);

        // stop during the low phase: no extra edge
        cyc(0, 0, 1, 0);
        n_done = 0;
        cyc(0, 0, 0, 1);
        idle(2);
        chk("stop_low_done", n_done, 1);
        chk("stop_low_edges", bus.edge_count, 0);

        // burst of three
        bus.burst_len = 3;
        n_done = 0;
        cyc(0, 0, 1, 0);
        idle(25);
        chk("burst_edges", bus.edge_count, 3);
        chk("burst_done", n_done, 1);
        chk("burst_idle", bus.busy, 0);

        // word change mid-high takes effect at the next wrap
        bus.burst_len = 0;
        cyc(0, 0, 1, 0);
        idle(6);
        for (int i = 0; i < 8 && !(bus.signal_out && hi_run == 1); i++) idle(1);
        chk("glitch_high", bus.signal_out, 1);
        bus.freq_word = 32'h2000_0000;
        min_hi = 1000;
        cyc(0, 1, 0, 0);
        idle(40);
        chk("glitch_period", per_len, 8);
        chk("glitch_no_runt", min_hi >= 2, 1);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 12 && bus.busy; i++) idle(1);
        chk("glitch_stopped", bus.busy, 0);

        // restart mid-burst, then reset mid-burst
        bus.freq_word = HALF_WORD;
        cyc(0, 1, 0, 0);
        bus.burst_len = 10;
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 40 && bus.edge_count != 5; i++) idle(1);
        chk("restart_at5", bus.edge_count, 5);
        n_done = 0;
        cyc(0, 0, 1, 0);
        chk("restart_cleared", bus.edge_count, 0);
        idle(50);
        chk("restart_edges", bus.edge_count, 10);
        chk("restart_done", n_done, 1);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 20 && bus.edge_count != 2; i++) idle(1);
        n_done = 0;
        cyc(1, 0, 0, 0);
        chk("reset_sig", bus.signal_out, 0);
        idle(4);
        chk("reset_no_done", n_done, 0);

        // same-cycle interactions and a zero word
        bus.freq_word = HALF_WORD;
        cyc(0, 1, 0, 0);
        bus.freq_word = 32'h1000_0000;
        bus.burst_len = 0;
        cyc(0, 1, 1, 0);
        idle(12);
        cyc(0, 0, 1, 1);
        idle(12);
        bus.freq_word = '0;
        cyc(0, 1, 0, 0);
        idle(40);
        cyc(0, 0, 0, 1);
        idle(5);
        chk("zero_word_stop", bus.busy, 0);

`ifdef FREQ_GEN_GATE_EN
        bus.freq_word = HALF_WORD;
        cyc(0, 1, 0, 0);
        bus.burst_len = 5;
        gated = 0;
        cyc(0, 0, 1, 0);
        idle(30);
        chk("gate_edges", gated, 5);
        chk("gate_low", bus.period, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
